// File: rtl/wb_commit_arbiter.sv
// Register-file write-port arbiter: merges MEM/WB results with buffered load responses.
// Optional macro WB_BYPASS_EN lets a response commit directly when the FIFO is empty.
module wb_commit_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       pipe_wren_i,
    input  logic [4:0]                 pipe_rd_addr_i,
    input  logic [31:0]                pipe_rd_data_i,
    input  logic                       ld_issue_i,
    input  logic [4:0]                 ld_issue_rd_i,
    input  logic                       ld_rsp_valid_i,
    output logic                       ld_rsp_ready_o,
    input  logic [4:0]                 ld_rsp_rd_i,
    input  logic [31:0]                ld_rsp_data_i,
    output logic                       rd_wren_o,
    output logic [4:0]                 rd_addr_o,
    output logic [31:0]                rd_data_o,
    output logic [31:0]                pending_o,
    output logic                       stall_req_o,
    output logic [$clog2(DEPTH+1)-1:0] buf_count_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

    logic [4:0]    fifo_rd_q   [DEPTH];
    logic [31:0]   fifo_data_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          stall_q, stall_d;
    logic          rd_wren_q, rd_wren_d;
    logic [4:0]    rd_addr_q, rd_addr_d;
    logic [31:0]   rd_data_q, rd_data_d;
    logic [31:0]   pending_q, pending_d;

    logic          pipe_hit, fifo_empty, rsp_live, push, pop, bypass;
    logic          commit_ld;
    logic [4:0]    commit_rd, head_rd;
    logic [31:0]   head_data, set_vec, clr_vec;

    assign head_rd    = fifo_rd_q[rd_ptr_q];
    assign head_data  = fifo_data_q[rd_ptr_q];
    assign fifo_empty = (count_q == '0);
    // Ready depends only on the registered count, so a full FIFO stays not-ready even while popping.
    assign ld_rsp_ready_o = (count_q < DEPTH_C);
    assign pipe_hit   = pipe_wren_i && (pipe_rd_addr_i != 5'd0);
    assign rsp_live   = ld_rsp_valid_i && ld_rsp_ready_o && (ld_rsp_rd_i != 5'd0);
    assign pop        = !pipe_hit && !fifo_empty;
`ifdef WB_BYPASS_EN
    assign bypass     = !pipe_hit && fifo_empty && rsp_live;
`else
    assign bypass     = 1'b0;
`endif
    assign push       = rsp_live && !bypass;

    always_comb begin
        rd_wren_d = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        commit_ld = 1'b0;
        commit_rd = head_rd;
        if (pipe_hit) begin
            rd_wren_d = 1'b1;
            rd_addr_d = pipe_rd_addr_i;
            rd_data_d = pipe_rd_data_i;
        end else if (!fifo_empty) begin
            rd_wren_d = 1'b1;
            rd_addr_d = head_rd;
            rd_data_d = head_data;
            commit_ld = 1'b1;
        end else if (bypass) begin
            rd_wren_d = 1'b1;
            rd_addr_d = ld_rsp_rd_i;
            rd_data_d = ld_rsp_data_i;
            commit_ld = 1'b1;
            commit_rd = ld_rsp_rd_i;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        stall_d  = stall_q;
        if (pop) begin
            starve_d = '0;
            stall_d  = 1'b0;
        end else begin
            // Bubble is requested one edge after the counter has reached its limit.
            if (starve_q >= STARVE_C) stall_d = 1'b1;
            if (fifo_empty) starve_d = '0;
            else if (pipe_hit && starve_q != STARVE_C) starve_d = starve_q + SW'(1);
        end
    end

    assign set_vec = (ld_issue_i && ld_issue_rd_i != 5'd0) ? (32'd1 << ld_issue_rd_i) : 32'd0;
    assign clr_vec = commit_ld ? (32'd1 << commit_rd) : 32'd0;

    // A new issue to the same register outranks the commit of the older load.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_pend
            if (gi == 0) begin : g_zero
                assign pending_d[gi] = 1'b0;
            end else begin : g_bit
                assign pending_d[gi] = set_vec[gi] | (pending_q[gi] & ~clr_vec[gi]);
            end
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]   <= ld_rsp_rd_i;
            fifo_data_q[wr_ptr_q] <= ld_rsp_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            stall_q   <= 1'b0;
            rd_wren_q <= 1'b0;
            rd_addr_q <= 5'd0;
            rd_data_q <= 32'd0;
            pending_q <= 32'd0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            starve_q  <= starve_d;
            stall_q   <= stall_d;
            rd_wren_q <= rd_wren_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            pending_q <= pending_d;
        end
    end

    assign rd_wren_o   = rd_wren_q;
    assign rd_addr_o   = rd_addr_q;
    assign rd_data_o   = rd_data_q;
    assign pending_o   = pending_q;
    assign stall_req_o = stall_q;
    assign buf_count_o = count_q;
endmodule
